// File: rtl/step_move_scheduler.sv
// step_move_scheduler: two-requester stepper move arbiter and pulse-train
// sequencer with absolute half-step position tracking.
// Build option: define SOFT_START_EN to run the first 4 pulses of every move
// at twice the effective period. Without it the period is constant.
module step_move_scheduler #(
  parameter int STEP_W = 8,
  parameter int POS_W  = 12,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  period,
  input  logic              a_valid,
  input  logic              a_dir,
  input  logic              a_half,
  input  logic [STEP_W-1:0] a_steps,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic              b_dir,
  input  logic              b_half,
  input  logic [STEP_W-1:0] b_steps,
  output logic              b_ready,
  input  logic              abort,
  output logic              step_pulse,
  output logic              step_dir,
  output logic              step_half,
  output logic              busy,
  output logic              grant_id,
  output logic              done,
  output logic              aborted,
  output logic [POS_W-1:0]  position
);

  // LOAD is the single cycle right after an accept; it keeps the divider
  // running so the first pulse still lands effective_period after accept.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

  state_t            state, stateNext;
  logic              rrPtr;
  logic [DIV_W:0]    divider;
  logic [STEP_W-1:0] remaining;
  logic [DIV_W-1:0]  effPeriod;
  logic [DIV_W:0]    compareLimit;
  logic              compareHit;
  logic              pickB;
  logic              accept;
  logic              fire;
  logic              abortNow;
  logic [POS_W-1:0]  posStep;

  // Periods of 0 and 1 are too short for a pulse/gap pair, clamp to 2
  always_comb effPeriod = (period < DIV_W'(2)) ? DIV_W'(2) : period;

`ifdef SOFT_START_EN
  logic [2:0] rampCount;

  // Doubled limit is formed one bit wider than the period so it cannot overflow
  always_comb compareLimit = (rampCount < 3'd4) ? ({effPeriod, 1'b0} - ONE)
                                                : ({1'b0, effPeriod} - ONE);

  // Count pulses of the current move, saturating once the ramp is over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rampCount <= 3'd0;
    end else if (accept) begin
      rampCount <= 3'd0;
    end else if (fire && (rampCount < 3'd4)) begin
      rampCount <= rampCount + 3'd1;
    end
  end
`else
  // Constant pulse spacing for the whole move
  always_comb compareLimit = {1'b0, effPeriod} - ONE;
`endif

  // Greater-or-equal so a period shortened mid-move fires at once instead of
  // letting the divider run all the way round
  always_comb compareHit = (divider >= compareLimit);

  // Arbitration: a lone requester wins, a tie goes to the round-robin pointer
  always_comb begin
    pickB   = b_valid & (~a_valid | rrPtr);
    a_ready = (state == IDLE) & ~rst & a_valid & ~pickB;
    b_ready = (state == IDLE) & ~rst & pickB;
    accept  = a_ready | b_ready;
  end

  // Signed position increment for one pulse of the current move
  always_comb begin
    case ({step_dir, step_half})
      2'b11:   posStep = POS_W'(1);
      2'b10:   posStep = POS_W'(2);
      2'b01:   posStep = ~POS_W'(0);
      default: posStep = ~POS_W'(1);
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and pulse decision; abort wins over a coinciding compare
  always_comb begin
    stateNext = state;
    fire      = 1'b0;
    abortNow  = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = LOAD;
      LOAD: begin
        if (abort) begin
          stateNext = DONE;
          abortNow  = 1'b1;
        end else begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          stateNext = DONE;
          abortNow  = 1'b1;
        end else if (remaining == '0) begin
          stateNext = DONE;
        end else if (compareHit) begin
          fire = 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Move datapath: latch on accept, time pulses, count down and track position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr      <= 1'b0;
      divider    <= '0;
      remaining  <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      step_half  <= 1'b0;
      grant_id   <= 1'b0;
      aborted    <= 1'b0;
      position   <= '0;
    end else begin
      step_pulse <= fire;
      if (accept) begin
        step_dir  <= pickB ? b_dir : a_dir;
        step_half <= pickB ? b_half : a_half;
        remaining <= pickB ? b_steps : a_steps;
        grant_id  <= pickB;
        rrPtr     <= ~pickB;
        divider   <= '0;
        aborted   <= 1'b0;
      end else if ((state == LOAD) || (state == RUN)) begin
        divider <= fire ? '0 : divider + ONE;
        if (abortNow) aborted <= 1'b1;
      end
      if (fire) begin
        remaining <= remaining - STEP_W'(1);
        position  <= position + posStep;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_step_move_scheduler.sv
// tb_step_move_scheduler: directed and randomized moves checked against a
// per-move event schedule (pulse offsets, done offset, position arithmetic).
module tb_step_move_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] period;
  logic        a_valid, a_dir, a_half, a_ready;
  logic [7:0]  a_steps;
  logic        b_valid, b_dir, b_half, b_ready;
  logic [7:0]  b_steps;
  logic        abort;
  logic        step_pulse, step_dir, step_half, busy, grant_id, done, aborted;
  logic [11:0] position;
  logic [20:0] outVec;

  int          nTests = 0;
  int          nFail  = 0;
  logic [11:0] mPos;
  bit          mRr;

  step_move_scheduler #(.STEP_W(8), .POS_W(12), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .period(period),
    .a_valid(a_valid), .a_dir(a_dir), .a_half(a_half), .a_steps(a_steps), .a_ready(a_ready),
    .b_valid(b_valid), .b_dir(b_dir), .b_half(b_half), .b_steps(b_steps), .b_ready(b_ready),
    .abort(abort), .step_pulse(step_pulse), .step_dir(step_dir), .step_half(step_half),
    .busy(busy), .grant_id(grant_id), .done(done), .aborted(aborted), .position(position)
  );

  always #5 clk = ~clk;

  assign outVec = {a_ready, b_ready, step_pulse, step_dir, step_half, busy, grant_id, done,
                   aborted, position};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offset from the accept edge of the k-th pulse of a move
  function automatic int pulseOfs(input int k, input int eff);
    int t;
    t = 0;
    for (int j = 1; j <= k; j++) begin
`ifdef SOFT_START_EN
      t += (j <= 4) ? 2 * eff : eff;
`else
      t += eff;
`endif
    end
    return t;
  endfunction

  // abortMode: 0 none, 1 abort right after pulse abortK, 2 random abort edge
  task automatic runMove(input bit aOn, input bit bOn, input int abortMode, input int abortK);
    bit gB, dv, hv, expP;
    int sv, eff, abortOfs, doneOfs, lastOfs, idx, delta, t;
    int offs[$];
    gB = bOn && (!aOn || mRr);
    a_valid = aOn;
    b_valid = bOn;
    #1;
    checkVal("ready", {30'd0, a_ready, b_ready}, gB ? 32'd1 : 32'd2);
    mRr = !gB;
    dv  = gB ? b_dir : a_dir;
    hv  = gB ? b_half : a_half;
    sv  = gB ? int'(b_steps) : int'(a_steps);
    eff = (period < 2) ? 2 : int'(period);
    lastOfs  = pulseOfs(sv, eff);
    abortOfs = 0;
    if (abortMode == 1) abortOfs = pulseOfs(abortK, eff) + 1;
    else if (abortMode == 2 && sv >= 2) abortOfs = int'($urandom_range(lastOfs, 2));
    for (int k = 1; k <= sv; k++) begin
      t = pulseOfs(k, eff);
      if (abortOfs == 0 || t < abortOfs) offs.push_back(t);
    end
    doneOfs = (abortOfs != 0) ? abortOfs : ((sv == 0) ? 2 : lastOfs + 1);
    delta   = (hv ? 1 : 2) * (dv ? 1 : -1);
    idx     = 0;
    @(posedge clk);
    for (int c = 0; c <= doneOfs; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (gB) b_valid = 1'b0;
        else    a_valid = 1'b0;
      end
      expP = (idx < offs.size()) && (offs[idx] == c);
      checkVal("pulse", step_pulse, expP);
      checkVal("done", done, c == doneOfs);
      checkVal("readyWhileBusy", {a_ready, b_ready}, 0);
      if (expP) begin
        idx++;
        mPos = mPos + 12'(delta);
        checkVal("pos", position, mPos);
      end
      if (abortOfs != 0 && c == abortOfs - 1) abort = 1'b1;
      if (c == doneOfs) begin
        abort = 1'b0;
        checkVal("aborted", aborted, abortOfs != 0);
        checkVal("grant", grant_id, gB);
        checkVal("dir", step_dir, dv);
        checkVal("half", step_half, hv);
        checkVal("busy", busy, 1);
        checkVal("endPos", position, mPos);
      end
    end
    @(negedge clk);
    checkVal("idle", {busy, done, step_pulse}, 0);
    $display("[TB] move grant=%0d dir=%0d half=%0d steps=%0d period=%0d pulses=%0d abortOfs=%0d pos=%03h",
             gB, dv, hv, sv, period, idx, abortOfs, position);
  endtask

  task automatic doReset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("rstOut", outVec, 0);
    @(negedge clk);
    rst  = 1'b0;
    mPos = '0;
    mRr  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; period = 16'd5; abort = 1'b0;
    a_valid = 0; a_dir = 0; a_half = 0; a_steps = 0;
    b_valid = 0; b_dir = 0; b_half = 0; b_steps = 0;
    mPos = '0; mRr = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rstHold", outVec, 0);
    rst = 1'b0;
    #1;
    checkVal("postRst", outVec, 0);

    // Basic full-step CW move
    period = 16'd5; a_dir = 1; a_half = 0; a_steps = 8'd3;
    runMove(1, 0, 0, 0);
    checkVal("t1pos", position, 12'd6);

    // Both requesters held: grants must alternate
    a_steps = 8'd1; b_steps = 8'd1; a_dir = 1; b_dir = 0; a_half = 1; b_half = 0;
    repeat (4) runMove(1, 1, 0, 0);
    a_valid = 0; b_valid = 0;

    // Zero-length move from B
    b_steps = 8'd0;
    runMove(0, 1, 0, 0);

    // Reset in the middle of a move
    @(negedge clk);
    period = 16'd3; b_dir = 1; b_half = 1; b_steps = 8'd20; b_valid = 1;
    @(posedge clk);
    @(negedge clk);
    b_valid = 0;
    repeat (6) @(negedge clk);
    checkVal("midPulse", step_pulse, 1);
    rst = 1'b1;
    #1;
    checkVal("rstMid", outVec, 0);
    @(negedge clk);
    rst = 1'b0; mPos = '0; mRr = 1'b0;

    // Half-step CCW move aborted after the 4th pulse
    period = 16'd3; a_dir = 0; a_half = 1; a_steps = 8'd10;
    runMove(1, 0, 1, 4);
    checkVal("abortPos", position, 12'hFFC);

    // Six-step move at period 3 (shows the ramp when enabled)
    a_dir = 1; a_half = 0; a_steps = 8'd6;
    runMove(1, 0, 0, 0);

    // Randomized moves
    for (int i = 0; i < 24; i++) begin
      int r;
      r = int'($urandom_range(3, 1));
      period  = 16'($urandom_range(6, 0));
      a_dir   = 1'($urandom); a_half = 1'($urandom); a_steps = 8'($urandom_range(12, 0));
      b_dir   = 1'($urandom); b_half = 1'($urandom); b_steps = 8'($urandom_range(12, 0));
      runMove(r[0], r[1], ($urandom_range(3, 0) == 0) ? 2 : 0, 0);
      a_valid = 0; b_valid = 0;
    end

    // Position wrap: walk to 0x7FE with period 0, then two more full steps
    doReset();
    period = 16'd0; a_dir = 1; a_half = 0;
    a_steps = 8'd255;
    repeat (4) runMove(1, 0, 0, 0);
    a_steps = 8'd3;
    runMove(1, 0, 0, 0);
    checkVal("prewrapPos", position, 12'h7FE);
    a_steps = 8'd2;
    runMove(1, 0, 0, 0);
    checkVal("wrapPos", position, 12'h802);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
